// File: rtl/debounce_edge_detect_if.sv
// Debounce/edge-detect signal bundle.
//   en     : debounce enable; low freezes the filter
//   din    : raw asynchronous input
//   level  : debounced, registered level
//   rise   : one-cycle pulse on level 0->1
//   fall   : one-cycle pulse on level 1->0
//   toggle : flips on every rise
//   busy   : high while a candidate transition is being qualified
// master drives en/din and observes the outputs; slave is the conditioning block.
interface debounce_edge_detect_if;
  logic en;
  logic din;
  logic level;
  logic rise;
  logic fall;
  logic toggle;
  logic busy;

  modport master (
    output en,
    output din,
    input  level,
    input  rise,
    input  fall,
    input  toggle,
    input  busy
  );

  modport slave (
    input  en,
    input  din,
    output level,
    output rise,
    output fall,
    output toggle,
    output busy
  );
endinterface

// File: rtl/debounce_edge_detect.sv
// Input conditioning stage: synchronises a raw bouncing input, qualifies each
// candidate transition over STABLE_CYCLES consecutive samples, and produces a
// clean level with single-cycle rise/fall pulses and a rise-driven toggle.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset (dominates en)
//   bus   : slave side of debounce_edge_detect_if (en, din in; level, rise,
//           fall, toggle, busy out)
module debounce_edge_detect #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned STABLE_CYCLES = 1000,
  parameter bit          INIT          = 1'b0
) (
  input logic                   clk,
  input logic                   rst_n,
  debounce_edge_detect_if.slave bus
);

  // Parameter legality is checked at elaboration.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : gen_sync_stages_check
    $error("SYNC_STAGES must be in the range 2..4");
  end
  if (STABLE_CYCLES == 0 ||
      64'(STABLE_CYCLES) > ((64'd1 << CNT_W) - 64'd1)) begin : gen_stable_cycles_check
    $error("STABLE_CYCLES must be in the range 1..2^CNT_W-1");
  end

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [0:0] {StStable, StCheck} state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   din_s;
  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   level_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   toggle_q;

  assign din_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q   <= {SYNC_STAGES{INIT}};
      state_q  <= StStable;
      cnt_q    <= '0;
      level_q  <= INIT;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      // Plain shift chain; keeps running while the filter is frozen.
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.din};
      // Pulses last one cycle unless re-asserted below.
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (bus.en) begin
        unique case (state_q)
          StStable: begin
            if (din_s != level_q) begin
              if (STABLE_CYCLES == 1) begin
                // A single disagreeing sample is already enough.
                level_q <= din_s;
                rise_q  <= din_s;
                fall_q  <= ~din_s;
                if (din_s) toggle_q <= ~toggle_q;
              end else begin
                state_q <= StCheck;
                cnt_q   <= CNT_W'(1);
              end
            end else begin
              cnt_q <= '0;
            end
          end
          StCheck: begin
            if (din_s == level_q) begin
              // Bounce back to the current level cancels the candidate.
              state_q <= StStable;
              cnt_q   <= '0;
            end else if (cnt_q == CntLast) begin
              level_q <= din_s;
              rise_q  <= din_s;
              fall_q  <= ~din_s;
              if (din_s) toggle_q <= ~toggle_q;
              state_q <= StStable;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_q <= StStable;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.level  = level_q;
  assign bus.rise   = rise_q;
  assign bus.fall   = fall_q;
  assign bus.toggle = toggle_q;
  assign bus.busy   = (state_q == StCheck);

endmodule

// File: tb/tb_debounce_edge_detect.sv
// Bench for debounce_edge_detect: DUT A (STABLE_CYCLES=4) and DUT B
// (STABLE_CYCLES=1). Stimulus pushes the expected pulse (cycle, flags) into a
// per-DUT queue; monitors pop and compare whenever rise or fall is seen.
module tb_debounce_edge_detect;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_na;
  logic rst_nb;

  debounce_edge_detect_if bus_a ();
  debounce_edge_detect_if bus_b ();

  debounce_edge_detect #(
    .SYNC_STAGES  (2),
    .CNT_W        (16),
    .STABLE_CYCLES(4),
    .INIT         (1'b0)
  ) u_dut_a (
    .clk  (clk),
    .rst_n(rst_na),
    .bus  (bus_a)
  );

  debounce_edge_detect #(
    .SYNC_STAGES  (2),
    .CNT_W        (16),
    .STABLE_CYCLES(1),
    .INIT         (1'b0)
  ) u_dut_b (
    .clk  (clk),
    .rst_n(rst_nb),
    .bus  (bus_b)
  );

  // flags = {rise, fall, level, toggle}
  typedef struct {
    int         cyc;
    logic [3:0] flags;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  bit tog_a  = 1'b0;
  bit tog_b  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic exp_a(input int c, input bit r, input bit f, input bit lvl);
    exp_t e;
    if (r) tog_a = ~tog_a;
    e.cyc   = c;
    e.flags = {r, f, lvl, tog_a};
    qa.push_back(e);
  endtask

  task automatic exp_b(input int c, input bit r, input bit f, input bit lvl);
    exp_t e;
    if (r) tog_b = ~tog_b;
    e.cyc   = c;
    e.flags = {r, f, lvl, tog_b};
    qb.push_back(e);
  endtask

  // Monitors
  always @(negedge clk) begin
    if (cyc > 0 && (bus_a.rise || bus_a.fall)) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_pulse", 32'({bus_a.rise, bus_a.fall, bus_a.level, bus_a.toggle}), 0);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_pulse_cycle", cyc, e.cyc);
        chk("a_pulse_flags", 32'({bus_a.rise, bus_a.fall, bus_a.level, bus_a.toggle}),
            32'(e.flags));
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0 && (bus_b.rise || bus_b.fall)) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_pulse", 32'({bus_b.rise, bus_b.fall, bus_b.level, bus_b.toggle}), 0);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_pulse_cycle", cyc, e.cyc);
        chk("b_pulse_flags", 32'({bus_b.rise, bus_b.fall, bus_b.level, bus_b.toggle}),
            32'(e.flags));
      end
    end
  end

  initial begin
    int c;
    rst_na     = 1'b0;
    rst_nb     = 1'b0;
    bus_a.en   = 1'b1;
    bus_a.din  = 1'b0;
    bus_b.en   = 1'b1;
    bus_b.din  = 1'b0;
    step(3);

    // Reset state
    chk("a_rst_level", bus_a.level, 0);
    chk("a_rst_rise", bus_a.rise, 0);
    chk("a_rst_fall", bus_a.fall, 0);
    chk("a_rst_toggle", bus_a.toggle, 0);
    chk("a_rst_busy", bus_a.busy, 0);
    chk("b_rst_level", bus_b.level, 0);
    rst_na = 1'b1;
    rst_nb = 1'b1;
    step(2);

    // Clean rise: level at relative edge 5, busy after edges 2..4
    c = cyc;
    bus_a.din = 1'b1;
    exp_a(c + 6, 1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 7; k++) begin
      step(1);
      chk("a_busy_rise", bus_a.busy, 32'(k >= 3 && k <= 5));
    end
    chk("a_level_after_rise", bus_a.level, 1);
    step(5);

    // Clean fall, toggle unchanged
    c = cyc;
    bus_a.din = 1'b0;
    exp_a(c + 6, 1'b0, 1'b1, 1'b0);
    step(10);
    chk("a_toggle_after_fall", bus_a.toggle, 1);

    // Bounce: 3 samples high, 1 low, then held high
    c = cyc;
    bus_a.din = 1'b1;
    step(3);
    bus_a.din = 1'b0;
    step(1);
    bus_a.din = 1'b1;
    exp_a(c + 10, 1'b1, 1'b0, 1'b1);
    step(1);
    chk("a_bounce_busy_hold", bus_a.busy, 1);
    step(1);
    chk("a_bounce_busy_drop", bus_a.busy, 0);
    chk("a_bounce_level_kept", bus_a.level, 0);
    step(8);
    chk("a_bounce_level_final", bus_a.level, 1);

    c = cyc;
    bus_a.din = 1'b0;
    exp_a(c + 6, 1'b0, 1'b1, 1'b0);
    step(10);

    // Two clean presses: 1, 0, 1 each held 10 cycles
    for (int p = 0; p < 3; p++) begin
      c = cyc;
      bus_a.din = (p != 1);
      exp_a(c + 6, p != 1, p == 1, p != 1);
      step(10);
    end
    chk("a_presses_toggle", bus_a.toggle, 0);
    chk("a_presses_level", bus_a.level, 1);

    // Enable freeze after 2 qualifying samples, for 5 edges
    c = cyc;
    bus_a.din = 1'b0;
    step(4);
    chk("a_en_busy_before", bus_a.busy, 1);
    bus_a.en = 1'b0;
    step(3);
    chk("a_en_busy_held", bus_a.busy, 1);
    chk("a_en_level_held", bus_a.level, 1);
    step(2);
    bus_a.en = 1'b1;
    exp_a(c + 11, 1'b0, 1'b1, 1'b0);
    step(1);
    chk("a_en_level_one_edge", bus_a.level, 1);
    step(1);
    chk("a_en_level_two_edges", bus_a.level, 0);
    step(8);

    // Bring toggle to 1 and level back to 0
    c = cyc;
    bus_a.din = 1'b1;
    exp_a(c + 6, 1'b1, 1'b0, 1'b1);
    step(10);
    c = cyc;
    bus_a.din = 1'b0;
    exp_a(c + 6, 1'b0, 1'b1, 1'b0);
    step(10);

    // Reset while qualifying (cnt=3)
    bus_a.din = 1'b1;
    step(5);
    chk("a_midchk_busy", bus_a.busy, 1);
    chk("a_midchk_toggle", bus_a.toggle, 1);
    rst_na    = 1'b0;
    bus_a.din = 1'b0;
    step(1);
    rst_na = 1'b1;
    tog_a  = 1'b0;
    chk("a_midrst_level", bus_a.level, 0);
    chk("a_midrst_busy", bus_a.busy, 0);
    chk("a_midrst_rise", bus_a.rise, 0);
    chk("a_midrst_toggle", bus_a.toggle, 0);
    step(10);
    chk("a_post_rst_level", bus_a.level, 0);

    // STABLE_CYCLES=1: level follows din_s one edge later
    c = cyc;
    bus_b.din = 1'b1;
    exp_b(c + 3, 1'b1, 1'b0, 1'b1);
    step(2);
    chk("b_level_before", bus_b.level, 0);
    step(1);
    chk("b_level_follow", bus_b.level, 1);
    chk("b_busy_idle", bus_b.busy, 0);
    step(2);
    c = cyc;
    bus_b.din = 1'b0;
    exp_b(c + 3, 1'b0, 1'b1, 1'b0);
    step(5);

    // Single-cycle glitch passes straight through
    c = cyc;
    bus_b.din = 1'b1;
    step(1);
    bus_b.din = 1'b0;
    exp_b(c + 3, 1'b1, 1'b0, 1'b1);
    exp_b(c + 4, 1'b0, 1'b1, 1'b0);
    step(8);
    chk("b_glitch_level", bus_b.level, 0);
    chk("b_glitch_toggle", bus_b.toggle, 0);

    step(3);
    chk("a_pending_pulses", qa.size(), 0);
    chk("b_pending_pulses", qb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_edge_detect.md
Name: debounce_edge_detect

Overview:
- Upstream conditioning stage for the flip-flop library: takes a raw, asynchronous, bouncing input (button, switch, external strobe) and produces a clean, synchronous level, plus single-cycle rise/fall pulses.
- Its outputs drive the d/clk/j/k inputs of the downstream d_flip_flop, jk_flip_flop and t_flip_flop cells.
- An integrated toggle output gives T-flip-flop behaviour driven by the debounced rising edge.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on din (legal range 2..4).
- CNT_W, 16, width of the stability counter.
- STABLE_CYCLES, 1000, consecutive clk edges din_s must disagree with level before level updates (legal range 1..2^CNT_W-1).
- INIT, 0, reset value of the synchronizer stages and of level.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- en  input  1  debounce enable; 0 freezes the filter.
- din  input  1  raw asynchronous input.
- level  output  1  debounced level (registered).
- rise  output  1  one-cycle pulse on level 0->1 (registered).
- fall  output  1  one-cycle pulse on level 1->0 (registered).
- toggle  output  1  flips on every rise (registered).
- busy  output  1  1 while a candidate transition is being qualified (state==CHECK).

Behaviour:
- Reset:
  - Sampled only at the rising clk edge while rst_n==0; no asynchronous path.
  - Reset values: all sync stages=INIT, level=INIT, rise=0, fall=0, toggle=0, cnt=0, state=STABLE, busy=0.
  - Reset dominates en.
- Synchronizer:
  - SYNC_STAGES-deep shift chain; din_s = last stage.
  - Runs regardless of en.
  - No logic between stages.
- State machine (2 states):
  - STABLE, din_s==level: stay; cnt=0.
  - STABLE, din_s!=level: if STABLE_CYCLES==1, update level at this edge and stay STABLE; else go to CHECK with cnt=1.
  - CHECK, din_s==level (bounce): go to STABLE, cnt=0, level unchanged, no pulse.
  - CHECK, din_s!=level, cnt==STABLE_CYCLES-1: level<=din_s, go to STABLE, cnt=0.
  - CHECK, din_s!=level, otherwise: cnt<=cnt+1.
- Update rule: level changes at the edge at which din_s has been sampled !=level on STABLE_CYCLES consecutive edges, that edge included.
- Latency: with din stable from before edge 0 (edges numbered from 0), level changes at edge SYNC_STAGES+STABLE_CYCLES-1.
- Pulses:
  - rise/fall assert at the same edge as level changes, for exactly one cycle; deasserted the following edge.
  - rise and fall are never both 1.
- toggle: inverted at the edge where rise is set. No reaction to fall.
- busy = (state==CHECK), decoded combinationally from the state register.
- en==0:
  - state, cnt, level and toggle hold.
  - rise and fall are forced to 0 at the next edge.
  - On en returning to 1, qualification resumes from the held cnt.
- Counter:
  - Never exceeds STABLE_CYCLES-1 and never wraps.
  - Elaboration-time check fails if STABLE_CYCLES==0 or STABLE_CYCLES>2^CNT_W-1, or if SYNC_STAGES is outside 2..4.
- Reset mid-CHECK: qualification is aborted; no pulse; level=INIT.
- Simultaneous events:
  - A din_s flip back to the current level in the same edge as the final qualifying count is not possible, because the rule is evaluated per sampled value.
  - An equal sample in CHECK always cancels the candidate transition.

Test Plan:
- SYNC_STAGES=2, STABLE_CYCLES=4, INIT=0; din 0->1 held from before edge 0 -> level=1 and rise=1 after edge 5; rise=0 after edge 6; toggle=1; busy=1 after edges 2..4.
- Bounce: din=1 for 3 cycles, then 0 for 1 cycle, then 1 held -> no change on the first burst (busy returns to 0); level rises 4 edges after din_s re-rises; exactly one rise pulse.
- Falling edge: from level=1, din 1->0 held -> level=0 with fall=1 for one cycle after edge 5; toggle unchanged.
- Two clean presses (0->1->0->1, each phase held 10 cycles) -> rise pulses=2, fall pulses=1, toggle returns to 0.
- en=0 asserted after 2 qualifying cycles for 5 cycles, then en=1 -> level changes 2 edges after en returns; no pulses while en=0.
- rst_n=0 for one edge while busy=1 (cnt=3) -> after that edge: level=0, busy=0, rise=0, toggle=0. STABLE_CYCLES=1 case: level follows din_s with 1-edge delay, and a rise pulse accompanies each 0->1.
